// File: rtl/operand_sel_pipe_pkg.sv
// Shared definitions for the operand selector: word width, source indices and
// the state encoding of the two-entry output buffer.
package operand_sel_pipe_pkg;

  localparam int WORD_W = 16;

  localparam int SRC_REG     = 0;
  localparam int SRC_IMM     = 1;
  localparam int SRC_FWD_EX  = 2;
  localparam int SRC_FWD_MEM = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: a head register drives the outputs, a skid register
// catches the one transfer accepted while the head is stalled.
module skid_buf2
  import operand_sel_pipe_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state_p1;
  state_t       state_nxt;
  logic [W-1:0] head_p1;
  logic [W-1:0] skid_p1;
  logic         push;
  logic         pop;
  logic         load_head_in;
  logic         load_head_skid;
  logic         load_skid;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) state_p1 <= ST_EMPTY;
    else              state_p1 <= state_nxt;
  end

  always_comb begin
    state_nxt      = state_p1;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p1)
      ST_EMPTY: begin
        if (push) begin
          state_nxt    = ST_ONE;
          load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      // The unused encoding drains to EMPTY rather than locking up.
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Stage p1: entry storage, cleared on reset and flush so nothing stale re-emerges.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_head_in)        head_p1 <= in_data;
      else if (load_head_skid) head_p1 <= skid_p1;
      if (load_skid)           skid_p1 <= in_data;
    end
  end

  always_comb begin
    in_ready  = (state_p1 != ST_FULL);
    out_valid = (state_p1 != ST_EMPTY);
    out_data  = head_p1;
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// N-way operand selector between decode and execute: indexed source pick plus
// range check, registered through a two-entry skid buffer toward the ALU.
module operand_sel_pipe
  import operand_sel_pipe_pkg::*;
#(
  parameter  int WIDTH  = WORD_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Returns {err, data}; an index matching no source yields err=1 with zero data.
  function automatic logic [WIDTH:0] select_operand(
    input logic [NUM_IN*WIDTH-1:0] srcs,
    input logic [SEL_W-1:0]        sel
  );
    logic [WIDTH:0] res;
    res = {1'b1, {WIDTH{1'b0}}};
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) res = {1'b0, srcs[k*WIDTH +: WIDTH]};
    end
    return res;
  endfunction

  logic [WIDTH:0] cand_p0;
  logic [WIDTH:0] head_p1;

  // Stage p0: combinational select of the incoming transfer.
  assign cand_p0 = select_operand(in_data, in_sel);

  skid_buf2 #(
    .W(WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (cand_p0),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (head_p1),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_err  = head_p1[WIDTH];
  assign out_data = head_p1[WIDTH-1:0];

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: a 4-source and a 3-source instance share clock,
// reset and flush; a capacity-2 queue per instance predicts every output.
module tb_operand_sel_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic [63:0] a_in_data = '0;
  logic [1:0]  a_in_sel = '0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [15:0] a_out_data;
  logic        a_out_err;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;

  logic [47:0] b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_out_data;
  logic        b_out_err;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;

  int checks = 0;
  int passed = 0;

  logic [16:0] qa[$];
  logic [16:0] qb[$];

  always #5 clk = ~clk;

  operand_sel_pipe #(.WIDTH(16), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(flush),
    .out_data(a_out_data), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  operand_sel_pipe #(.WIDTH(16), .NUM_IN(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(flush),
    .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  function automatic logic [16:0] expect_entry(input logic [255:0] d, input int sel, input int n);
    if (sel >= n) return {1'b1, 16'h0000};
    return {1'b0, d[sel*16 +: 16]};
  endfunction

  // One clock edge: the queues follow the transfer rules using pre-edge inputs.
  task automatic tick();
    logic [16:0] ea, eb;
    bit pa, pb, oa, ob, clr;
    ea  = expect_entry(256'(a_in_data), int'(a_in_sel), 4);
    eb  = expect_entry(256'(b_in_data), int'(b_in_sel), 3);
    pa  = a_in_valid && (qa.size() < 2);
    pb  = b_in_valid && (qb.size() < 2);
    oa  = a_out_ready && (qa.size() > 0);
    ob  = b_out_ready && (qb.size() > 0);
    clr = rst || flush;
    @(posedge clk);
    if (clr) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) void'(qa.pop_front());
      if (pa) qa.push_back(ea);
      if (ob) void'(qb.pop_front());
      if (pb) qb.push_back(eb);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", a_out_valid); else passed++;
    checks++; if (a_out_data !== 16'h0) $display("FAIL reset_data got=%h exp=0000", a_out_data); else passed++;
    checks++; if (a_out_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", a_out_err); else passed++;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", a_in_ready); else passed++;
    checks++; if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid got=%b exp=0", b_out_valid); else passed++;
  endtask

  task automatic test_first_push();
    a_in_data   = {16'h0, 16'h0, 16'h00F3, 16'h0};
    a_in_sel    = 2'd1;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1) $display("FAIL first_valid got=%b exp=1", a_out_valid); else passed++;
    checks++; if (a_out_data !== 16'h00F3) $display("FAIL first_data got=%h exp=00f3", a_out_data); else passed++;
    checks++; if (a_out_err !== 1'b0) $display("FAIL first_err got=%b exp=0", a_out_err); else passed++;
    tick();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL first_drain got=%b exp=0", a_out_valid); else passed++;
  endtask

  task automatic test_stream();
    logic [15:0] exp;
    a_in_data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_sel   = 2'(i);
      a_in_valid = 1'b1;
      checks++; if (a_in_ready !== 1'b1) $display("FAIL stream_ready[%0d] got=%b exp=1", i, a_in_ready); else passed++;
      tick();
      exp = 16'h1111 * 16'(i + 1);
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp)
        $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, a_out_valid, a_out_data, exp); else passed++;
    end
    a_in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", a_out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    a_out_ready = 1'b0;
    a_in_sel    = 2'd0;
    a_in_data   = {48'h0, 16'hAAAA};
    a_in_valid  = 1'b1;
    tick();
    a_in_data = {48'h0, 16'hBBBB};
    tick();
    a_in_valid = 1'b0;
    checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", a_in_ready); else passed++;
    checks++; if (a_out_data !== 16'hAAAA) $display("FAIL bp_head got=%h exp=aaaa", a_out_data); else passed++;
    repeat (2) begin
      a_in_valid = 1'b1;
      a_in_data  = {48'h0, 16'hDEAD};
      tick();
      checks++; if (a_out_data !== 16'hAAAA || a_out_valid !== 1'b1)
        $display("FAIL bp_stable got=%b/%h exp=1/aaaa", a_out_valid, a_out_data); else passed++;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_data !== 16'hBBBB || a_out_valid !== 1'b1)
      $display("FAIL bp_second got=%b/%h exp=1/bbbb", a_out_valid, a_out_data); else passed++;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_again got=%b exp=1", a_in_ready); else passed++;
    tick();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", a_out_valid); else passed++;
  endtask

  task automatic test_out_of_range();
    b_in_data   = {16'h5A5A, 16'h7777, 16'h6666};
    b_out_ready = 1'b1;
    b_in_sel    = 2'd3;
    b_in_valid  = 1'b1;
    tick();
    b_in_sel = 2'd2;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h0 || b_out_err !== 1'b1)
      $display("FAIL oor_sel3 got=%b/%h/%b exp=1/0000/1", b_out_valid, b_out_data, b_out_err); else passed++;
    tick();
    b_in_valid = 1'b0;
    checks++; if (b_out_data !== 16'h5A5A || b_out_err !== 1'b0)
      $display("FAIL oor_sel2 got=%h/%b exp=5a5a/0", b_out_data, b_out_err); else passed++;
    tick();
    checks++; if (b_out_valid !== 1'b0) $display("FAIL oor_drain got=%b exp=0", b_out_valid); else passed++;
    b_out_ready = 1'b0;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_sel    = 2'd0;
    a_in_valid  = 1'b1;
    a_in_data   = {48'h0, 16'h1234};
    tick();
    a_in_data = {48'h0, 16'h5678};
    tick();
    checks++; if (a_in_ready !== 1'b0) $display("FAIL flush_pre_full got=%b exp=0", a_in_ready); else passed++;
    a_in_data = {48'h0, 16'hCCCC};
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL flush_full got=%b/%b exp=0/1", a_out_valid, a_in_ready); else passed++;
    // Flush while ONE: in_ready is high, yet the offered transfer must still be dropped.
    a_in_valid = 1'b1;
    a_in_data  = {48'h0, 16'h9999};
    tick();
    a_in_data = {48'h0, 16'hCCCC};
    flush     = 1'b1;
    checks++; if (a_in_ready !== 1'b1) $display("FAIL flush_one_ready got=%b exp=1", a_in_ready); else passed++;
    tick();
    flush = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (a_out_valid !== 1'b0)
        $display("FAIL flush_no_cccc[%0d] got=%b/%h exp=0", i, a_out_valid, a_out_data); else passed++;
      tick();
    end
  endtask

  task automatic test_rst_mid();
    a_out_ready = 1'b1;
    a_in_sel    = 2'd2;
    a_in_valid  = 1'b1;
    a_in_data   = {16'h0, 16'h7E7E, 32'h0};
    tick();
    checks++; if (a_out_valid !== 1'b1) $display("FAIL rstmid_pre got=%b exp=1", a_out_valid); else passed++;
    a_in_data = {16'h0, 16'h8181, 32'h0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 16'h0 || a_out_err !== 1'b0)
      $display("FAIL rstmid_after got=%b/%h/%b exp=0/0000/0", a_out_valid, a_out_data, a_out_err); else passed++;
    repeat (3) tick();
    checks++; if (a_out_valid !== 1'b0) $display("FAIL rstmid_stale got=%b/%h exp=0", a_out_valid, a_out_data); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_in_data   = {$urandom, $urandom};
      a_in_sel    = 2'($urandom_range(0, 3));
      a_in_valid  = 1'($urandom_range(0, 3) != 0);
      a_out_ready = 1'($urandom_range(0, 2) != 0);
      b_in_data   = 48'({$urandom, $urandom});
      b_in_sel    = 2'($urandom_range(0, 3));
      b_in_valid  = 1'($urandom_range(0, 1));
      b_out_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 40) == 0);
      tick();
      checks++; if (a_out_valid !== (qa.size() > 0) || a_in_ready !== (qa.size() < 2))
        $display("FAIL rand_a_ctl[%0d] got=%b/%b exp_depth=%0d", c, a_out_valid, a_in_ready, qa.size()); else passed++;
      if (qa.size() > 0) begin
        checks++; if ({a_out_err, a_out_data} !== qa[0])
          $display("FAIL rand_a_data[%0d] got=%b/%h exp=%b/%h", c, a_out_err, a_out_data, qa[0][16], qa[0][15:0]); else passed++;
      end
      checks++; if (b_out_valid !== (qb.size() > 0) || b_in_ready !== (qb.size() < 2))
        $display("FAIL rand_b_ctl[%0d] got=%b/%b exp_depth=%0d", c, b_out_valid, b_in_ready, qb.size()); else passed++;
      if (qb.size() > 0) begin
        checks++; if ({b_out_err, b_out_data} !== qb[0])
          $display("FAIL rand_b_data[%0d] got=%b/%h exp=%b/%h", c, b_out_err, b_out_data, qb[0][16], qb[0][15:0]); else passed++;
      end
    end
    flush      = 1'b0;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_stream();
    test_back_to_back();
    test_out_of_range();
    test_flush();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
